execute_stage: RTL and testbench

- EX stage of the 5-stage MIPS pipeline. Sits directly downstream of instruction decode and consumes its DX_* pipeline register.
- Computes the ALU result or memory address and resolves beq/j.
- Registers the XM_* pipeline register for the memory stage.
- Drives a PC redirect to fetch, then squashes wrong-path instructions that arrive from decode after a taken branch/jump.

---
 rtl/execute_stage.sv | 132 +++++++++++++
 tb/tb_execute_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// EX stage: ALU / effective address, beq/j resolution, XM pipeline register, PC redirect and wrong-path squash.
// Latency: 1 cycle from DX inputs to XM outputs; pc_redirect pulses the cycle after a taken branch/jump edge.
// Backpressure: stall=1 freezes every register (flush counter and state included) and clears the redirect pulse.
module execute_stage #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] DX_rtData,
    input  logic [4:0]  RD,
    input  logic [2:0]  ALUctr,
    input  logic        DX_lwFlag,
    input  logic        DX_swFlag,
    input  logic [2:0]  DX_compareFlag,
    input  logic [31:0] DX_PC,
    input  logic        stall,
    output logic [31:0] XM_ALUout,
    output logic [31:0] XM_BD,
    output logic [4:0]  XM_RD,
    output logic        XM_lwFlag,
    output logic        XM_swFlag,
    output logic [2:0]  XM_compareFlag,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        flushing
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t      state;
    logic [2:0]  flush_cnt;

    logic        op_add, op_sub, op_cmp;
    logic        is_slt, is_beq, is_j, op_valid;
    logic        slt_lt;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] nxt_alu, nxt_bd;
    logic [4:0]  nxt_rd;
    logic        nxt_lw, nxt_sw;
    logic [2:0]  nxt_cf;

    // Decode the DX register and compute what this instruction would write into XM.
    always_comb begin
        op_add   = (ALUctr == 3'd0);
        op_sub   = (ALUctr == 3'd1);
        op_cmp   = (ALUctr == 3'd2);
        is_slt   = op_cmp && (DX_compareFlag == 3'd0);
        is_beq   = op_cmp && (DX_compareFlag == 3'd1);
        is_j     = op_cmp && (DX_compareFlag == 3'd2);
        op_valid = op_add || op_sub || is_slt || is_beq || is_j;
        slt_lt   = ($signed(A) < $signed(B));

        nxt_alu = 32'd0;
        if (op_valid) begin
            if (DX_lwFlag || DX_swFlag || op_add) nxt_alu = A + B;
            else if (op_sub)                      nxt_alu = A - B;
            else if (is_slt)                      nxt_alu = {31'd0, slt_lt};
        end

        // Stores and control transfers never write the register file.
        nxt_rd = (op_valid && !DX_swFlag && !is_beq && !is_j) ? RD : 5'd0;
        nxt_lw = op_valid && DX_lwFlag;
        nxt_sw = op_valid && DX_swFlag;
        nxt_bd = nxt_sw ? DX_rtData : 32'd0;
        nxt_cf = op_valid ? DX_compareFlag : 3'd0;

        br_taken  = is_j || (is_beq && (A == DX_rtData));
        br_target = is_j ? {DX_PC[31:28], B[25:0], 2'b00}
                         : DX_PC + {B[29:0], 2'b00};
    end

    // Run/flush state machine together with the XM register and the redirect outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= RUN;
            flush_cnt      <= 3'd0;
            XM_ALUout      <= 32'd0;
            XM_BD          <= 32'd0;
            XM_RD          <= 5'd0;
            XM_lwFlag      <= 1'b0;
            XM_swFlag      <= 1'b0;
            XM_compareFlag <= 3'd0;
            pc_redirect    <= 1'b0;
            redirect_pc    <= 32'd0;
            flushing       <= 1'b0;
        end else if (stall) begin
            // Everything holds except the pulse, so fetch never sees a redirect twice.
            pc_redirect <= 1'b0;
        end else begin
            pc_redirect <= 1'b0;
            case (state)
                FLUSH: begin
                    // Wrong-path instruction: retire it as a bubble.
                    XM_ALUout      <= 32'd0;
                    XM_BD          <= 32'd0;
                    XM_RD          <= 5'd0;
                    XM_lwFlag      <= 1'b0;
                    XM_swFlag      <= 1'b0;
                    XM_compareFlag <= 3'd0;
                    flush_cnt      <= flush_cnt - 3'd1;
                    if (flush_cnt <= 3'd1) begin
                        state    <= RUN;
                        flushing <= 1'b0;
                    end
                end
                default: begin
                    XM_ALUout      <= nxt_alu;
                    XM_BD          <= nxt_bd;
                    XM_RD          <= nxt_rd;
                    XM_lwFlag      <= nxt_lw;
                    XM_swFlag      <= nxt_sw;
                    XM_compareFlag <= nxt_cf;
                    if (br_taken) begin
                        pc_redirect <= 1'b1;
                        redirect_pc <= br_target;
                        if (FLUSH_LOAD != 3'd0) begin
                            flush_cnt <= FLUSH_LOAD;
                            state     <= FLUSH;
                            flushing  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed table, hand-written flush/stall/reset sequences, random run vs. a reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: stall driven both in the directed sequences and randomly.
module tb_execute_stage;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A, B, DX_rtData, DX_PC;
    logic [4:0]  RD;
    logic [2:0]  ALUctr, DX_compareFlag;
    logic        DX_lwFlag, DX_swFlag, stall;
    logic [31:0] XM_ALUout, XM_BD, redirect_pc;
    logic [4:0]  XM_RD;
    logic        XM_lwFlag, XM_swFlag, pc_redirect, flushing;
    logic [2:0]  XM_compareFlag;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    execute_stage #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .DX_rtData(DX_rtData), .RD(RD),
        .ALUctr(ALUctr), .DX_lwFlag(DX_lwFlag), .DX_swFlag(DX_swFlag),
        .DX_compareFlag(DX_compareFlag), .DX_PC(DX_PC), .stall(stall),
        .XM_ALUout(XM_ALUout), .XM_BD(XM_BD), .XM_RD(XM_RD),
        .XM_lwFlag(XM_lwFlag), .XM_swFlag(XM_swFlag), .XM_compareFlag(XM_compareFlag),
        .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .flushing(flushing)
    );

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] bd;
        logic [4:0]  rd;
        logic        lw;
        logic        sw;
        logic [2:0]  cf;
        logic        taken;
        logic [31:0] tgt;
    } res_t;

    typedef struct {
        logic [2:0]  ctr;
        logic [2:0]  cf;
        logic        lw;
        logic        sw;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rt;
        logic [4:0]  rd;
        logic [31:0] e_alu;
        logic [31:0] e_bd;
        logic [4:0]  e_rd;
        logic        e_lw;
        logic        e_sw;
        logic [2:0]  e_cf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [2:0] ctr, input logic [2:0] cf, input logic lw, input logic sw,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] rt,
                          input logic [4:0] rd, input logic [31:0] pc);
        ALUctr = ctr; DX_compareFlag = cf; DX_lwFlag = lw; DX_swFlag = sw;
        A = a; B = b; DX_rtData = rt; RD = rd; DX_PC = pc;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".alu"}, XM_ALUout, 32'd0);
        chk({tag, ".bd"}, XM_BD, 32'd0);
        chk({tag, ".rd"}, {27'd0, XM_RD}, 32'd0);
        chk({tag, ".lw"}, {31'd0, XM_lwFlag}, 32'd0);
        chk({tag, ".sw"}, {31'd0, XM_swFlag}, 32'd0);
        chk({tag, ".cf"}, {29'd0, XM_compareFlag}, 32'd0);
        chk({tag, ".redir"}, {31'd0, pc_redirect}, 32'd0);
        chk({tag, ".rpc"}, redirect_pc, 32'd0);
        chk({tag, ".flushing"}, {31'd0, flushing}, 32'd0);
    endtask

    // Instruction semantics straight from the ISA rules: what one instruction does in isolation.
    function automatic res_t ref_model(input logic [2:0] ctr, input logic [2:0] cf, input logic lw,
                                       input logic sw, input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] rt, input logic [4:0] rd, input logic [31:0] pc);
        res_t r;
        r = '0;
        case (ctr)
            3'd0: begin
                r.alu = a + b; r.lw = lw; r.sw = sw; r.cf = cf;
                r.rd  = sw ? 5'd0 : rd;
                r.bd  = sw ? rt : 32'd0;
            end
            3'd1: begin
                r.alu = a - b; r.rd = rd; r.cf = cf;
            end
            3'd2: begin
                case (cf)
                    3'd0: begin
                        r.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        r.rd  = rd;
                    end
                    3'd1: begin
                        r.cf = 3'd1; r.taken = (a == rt);
                        r.tgt = pc + b * 32'd4;
                    end
                    3'd2: begin
                        r.cf = 3'd2; r.taken = 1'b1;
                        r.tgt = (pc & 32'hF000_0000) | ((b & 32'h03FF_FFFF) * 32'd4);
                    end
                    default: r = '0;
                endcase
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    vec_t tbl[10];

    initial begin
        res_t        r, m_out;
        int          m_left;
        logic        m_redir;
        logic [31:0] m_rpc;
        logic [15:0] imm;
        int          kind;

        // ctr cf lw sw a b rt rd | alu bd rd lw sw cf
        tbl[0] = '{3'd0, 3'd0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd3, 32'd12, 32'd0, 5'd3, 1'b0, 1'b0, 3'd0};
        tbl[1] = '{3'd2, 3'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd2, 32'd1, 32'd0, 5'd2, 1'b0, 1'b0, 3'd0};
        tbl[2] = '{3'd1, 3'd0, 1'b0, 1'b0, 32'd3, 32'd5, 32'd0, 5'd1, 32'hFFFF_FFFE, 32'd0, 5'd1, 1'b0, 1'b0, 3'd0};
        tbl[3] = '{3'd0, 3'd0, 1'b0, 1'b1, 32'h100, 32'd8, 32'hDEAD, 5'd9, 32'h108, 32'hDEAD, 5'd0, 1'b0, 1'b1, 3'd0};
        tbl[4] = '{3'd0, 3'd0, 1'b1, 1'b0, 32'h200, 32'd4, 32'h55, 5'd6, 32'h204, 32'd0, 5'd6, 1'b1, 1'b0, 3'd0};
        tbl[5] = '{3'd2, 3'd0, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd2, 32'd0, 32'd0, 5'd2, 1'b0, 1'b0, 3'd0};
        tbl[6] = '{3'd5, 3'd0, 1'b1, 1'b0, 32'd1, 32'd2, 32'd0, 5'd4, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 3'd0};
        tbl[7] = '{3'd2, 3'd4, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 5'd4, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 3'd0};
        tbl[8] = '{3'd2, 3'd1, 1'b0, 1'b0, 32'd1, 32'd4, 32'd2, 5'd3, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 3'd1};
        tbl[9] = '{3'd0, 3'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd7, 32'd1, 32'd0, 5'd7, 1'b0, 1'b0, 3'd0};

        // Reset state
        rst = 1'b0; stall = 1'b0;
        set_in(3'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0);
        step(); step();
        chk_all_zero("reset");
        rst = 1'b1;

        // Directed single-instruction vectors from RUN
        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].ctr, tbl[i].cf, tbl[i].lw, tbl[i].sw, tbl[i].a, tbl[i].b, tbl[i].rt, tbl[i].rd, 32'h1000);
            step();
            chk($sformatf("vec%0d.alu", i), XM_ALUout, tbl[i].e_alu);
            chk($sformatf("vec%0d.bd", i), XM_BD, tbl[i].e_bd);
            chk($sformatf("vec%0d.rd", i), {27'd0, XM_RD}, {27'd0, tbl[i].e_rd});
            chk($sformatf("vec%0d.lw", i), {31'd0, XM_lwFlag}, {31'd0, tbl[i].e_lw});
            chk($sformatf("vec%0d.sw", i), {31'd0, XM_swFlag}, {31'd0, tbl[i].e_sw});
            chk($sformatf("vec%0d.cf", i), {29'd0, XM_compareFlag}, {29'd0, tbl[i].e_cf});
            chk($sformatf("vec%0d.redir", i), {31'd0, pc_redirect}, 32'd0);
            chk($sformatf("vec%0d.flushing", i), {31'd0, flushing}, 32'd0);
        end

        // Taken beq followed by two squashed adds and one surviving add
        set_in(3'd2, 3'd1, 1'b0, 1'b0, 32'd9, 32'hFFFF_FFFE, 32'd9, 5'd0, 32'h40);
        step();
        chk("beq.redir", {31'd0, pc_redirect}, 32'd1);
        chk("beq.rpc", redirect_pc, 32'h38);
        chk("beq.flushing", {31'd0, flushing}, 32'd1);
        chk("beq.rd", {27'd0, XM_RD}, 32'd0);
        chk("beq.alu", XM_ALUout, 32'd0);
        set_in(3'd0, 3'd0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 5'd4, 32'h44);
        step();
        chk("sq4.redir", {31'd0, pc_redirect}, 32'd0);
        chk("sq4.flushing", {31'd0, flushing}, 32'd1);
        chk("sq4.rd", {27'd0, XM_RD}, 32'd0);
        chk("sq4.alu", XM_ALUout, 32'd0);
        set_in(3'd0, 3'd0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 5'd5, 32'h48);
        step();
        chk("sq5.flushing", {31'd0, flushing}, 32'd0);
        chk("sq5.rd", {27'd0, XM_RD}, 32'd0);
        chk("sq5.rpc_hold", redirect_pc, 32'h38);
        set_in(3'd0, 3'd0, 1'b0, 1'b0, 32'd2, 32'd3, 32'd0, 5'd6, 32'h3C);
        step();
        chk("post6.rd", {27'd0, XM_RD}, 32'd6);
        chk("post6.alu", XM_ALUout, 32'd5);
        chk("post6.redir", {31'd0, pc_redirect}, 32'd0);

        // Jump, then stall for three edges in the middle of the flush
        set_in(3'd2, 3'd2, 1'b0, 1'b0, 32'd0, 32'h10, 32'd0, 5'd0, 32'h8000_0010);
        step();
        chk("j.redir", {31'd0, pc_redirect}, 32'd1);
        chk("j.rpc", redirect_pc, 32'h8000_0040);
        chk("j.flushing", {31'd0, flushing}, 32'd1);
        chk("j.rd", {27'd0, XM_RD}, 32'd0);
        stall = 1'b1;
        set_in(3'd0, 3'd0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 5'd8, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall%0d.redir", i), {31'd0, pc_redirect}, 32'd0);
            chk($sformatf("stall%0d.flushing", i), {31'd0, flushing}, 32'd1);
            chk($sformatf("stall%0d.rd", i), {27'd0, XM_RD}, 32'd0);
            chk($sformatf("stall%0d.rpc", i), redirect_pc, 32'h8000_0040);
        end
        stall = 1'b0;
        step();
        chk("jsq8.flushing", {31'd0, flushing}, 32'd1);
        chk("jsq8.rd", {27'd0, XM_RD}, 32'd0);
        chk("jsq8.redir", {31'd0, pc_redirect}, 32'd0);
        set_in(3'd0, 3'd0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 5'd9, 32'd0);
        step();
        chk("jsq9.flushing", {31'd0, flushing}, 32'd0);
        chk("jsq9.rd", {27'd0, XM_RD}, 32'd0);
        set_in(3'd0, 3'd0, 1'b0, 1'b0, 32'd4, 32'd4, 32'd0, 5'd10, 32'd0);
        step();
        chk("j10.rd", {27'd0, XM_RD}, 32'd10);
        chk("j10.alu", XM_ALUout, 32'd8);

        // Asynchronous reset in the middle of a flush
        set_in(3'd2, 3'd2, 1'b0, 1'b0, 32'd0, 32'h20, 32'd0, 5'd0, 32'd0);
        step();
        chk("j2.flushing", {31'd0, flushing}, 32'd1);
        chk("j2.redir", {31'd0, pc_redirect}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_all_zero("midrst");
        #1 rst = 1'b1;
        set_in(3'd0, 3'd0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 5'd7, 32'd0);
        step();
        chk("afterrst.rd", {27'd0, XM_RD}, 32'd7);
        chk("afterrst.alu", XM_ALUout, 32'd2);
        chk("afterrst.flushing", {31'd0, flushing}, 32'd0);

        // Random traffic against the reference model
        rst = 1'b0;
        step();
        rst = 1'b1;
        m_left = 0; m_redir = 1'b0; m_rpc = 32'd0; m_out = '0;
        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom_range(0, 9));
            set_in(3'd0, 3'd0, 1'b0, 1'b0, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)), $urandom);
            case (kind)
                1: ALUctr = 3'd1;
                2: begin ALUctr = 3'd2; DX_compareFlag = 3'd0; end
                3: DX_lwFlag = 1'b1;
                4: DX_swFlag = 1'b1;
                5: begin
                    ALUctr = 3'd2; DX_compareFlag = 3'd1;
                    imm = 16'($urandom);
                    B = {{16{imm[15]}}, imm};
                    if ($urandom_range(0, 1) == 1) DX_rtData = A;
                end
                6: begin ALUctr = 3'd2; DX_compareFlag = 3'd2; end
                7: begin
                    ALUctr = 3'($urandom_range(3, 7));
                    DX_compareFlag = 3'($urandom_range(0, 7));
                    DX_lwFlag = 1'($urandom_range(0, 1));
                    DX_swFlag = 1'($urandom_range(0, 1));
                end
                8: begin ALUctr = 3'd2; DX_compareFlag = 3'($urandom_range(3, 7)); end
                9: RD = 5'd0;
                default: ;
            endcase
            stall = ($urandom_range(0, 4) == 0);
            r = ref_model(ALUctr, DX_compareFlag, DX_lwFlag, DX_swFlag, A, B, DX_rtData, RD, DX_PC);
            step();
            m_redir = 1'b0;
            if (!stall) begin
                if (m_left > 0) begin
                    m_out = '0;
                    m_left--;
                end else begin
                    m_out = r;
                    if (r.taken) begin
                        m_redir = 1'b1;
                        m_rpc = r.tgt;
                        m_left = FC;
                    end
                end
            end
            chk($sformatf("rnd%0d.alu", n), XM_ALUout, m_out.alu);
            chk($sformatf("rnd%0d.bd", n), XM_BD, m_out.bd);
            chk($sformatf("rnd%0d.rd", n), {27'd0, XM_RD}, {27'd0, m_out.rd});
            chk($sformatf("rnd%0d.lw", n), {31'd0, XM_lwFlag}, {31'd0, m_out.lw});
            chk($sformatf("rnd%0d.sw", n), {31'd0, XM_swFlag}, {31'd0, m_out.sw});
            chk($sformatf("rnd%0d.cf", n), {29'd0, XM_compareFlag}, {29'd0, m_out.cf});
            chk($sformatf("rnd%0d.redir", n), {31'd0, pc_redirect}, {31'd0, m_redir});
            chk($sformatf("rnd%0d.rpc", n), redirect_pc, m_rpc);
            chk($sformatf("rnd%0d.flushing", n), {31'd0, flushing}, (m_left > 0) ? 32'd1 : 32'd0);
        end
        stall = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
